// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_mux_pkg
// Brief   : Default sizing constants and the channel-index width helper.
// Rev     : 1.0  initial release
// ============================================================================
package arb_mux_pkg;

    localparam int ARB_MUX_WIDTH    = 16;
    localparam int ARB_MUX_CHANNELS = 8;

    // Smallest w with 2**w >= n, same result as $clog2 for n >= 1.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational rotating-priority arbiter; ptr names the first
//           channel searched, wrapping modulo CHANNELS.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = ARB_MUX_CHANNELS,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grant_idx,
    output logic                grant_vld
);

    // One spare bit so ptr + k never overflows before the modulo fold.
    logic [SELW:0] w_idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = {1'b0, ptr} + (SELW+1)'(k);
            if (w_idx >= (SELW+1)'(CHANNELS)) begin
                w_idx = w_idx - (SELW+1)'(CHANNELS);
            end
            if (!grant_vld && req[w_idx[SELW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = w_idx[SELW-1:0];
            end
        end
        grant = grant_vld ? (CHANNELS'(1) << grant_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : arb_mux
// Brief   : N-to-1 arbitrated mux with a single-entry registered output.
//           Define ARB_MUX_FIXED_PRIO_EN for fixed lowest-index priority
//           instead of round-robin.
// Rev     : 1.0  initial release
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH    = ARB_MUX_WIDTH,
    parameter  int CHANNELS = ARB_MUX_CHANNELS,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                w_ld;
    logic                w_any;
    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_gidx;
    logic [SELW-1:0]     w_ptr;
    logic [WIDTH-1:0]    w_gdata;

    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_sel;
    logic                r_out_valid;

    assign w_ld = !r_out_valid || out_ready;

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [SELW-1:0] r_ptr;

    assign w_ptr = r_ptr;

    // Explicit wrap so non-power-of-two channel counts return to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_ld && w_any) begin
            r_ptr <= (w_gidx == SELW'(CHANNELS-1)) ? '0 : w_gidx + 1'b1;
        end
    end
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (w_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_vld (w_any)
    );

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gidx == SELW'(i)) w_gdata = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign in_ready = (w_ld && !rst) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_ld) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_gdata;
                r_out_sel  <= w_gidx;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
